dmem_mmio: RTL and testbench
============================

DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, RAM size in 32-bit words (power of two, at most 1024).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, UART bit period in clk cycles (at least 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port MemWrite, input, 1, store strobe from the core memory stage.
REQ-006 SHALL have port DataAdr, input, 32, byte address from the core memory stage.
REQ-007 SHALL have port WriteData, input, 32, store data.
REQ-008 SHALL have port ReadData, output, 32, load data, combinational from DataAdr and current state.
REQ-009 SHALL have port led, output, 8, LED register contents.
REQ-010 SHALL have port uart_tx, output, 1, serial 8N1 transmit line.

Function
REQ-011 SHALL decode the address map as follows, with DataAdr[1:0] ignored:
- RAM at 0x0000_0000 to 4*DEPTH_WORDS-1.
- LED at 0x0000_1000.
- TIMER at 0x0000_1004.
- UART_DATA at 0x0000_1008.
- UART_STAT at 0x0000_100C.
REQ-012 SHALL write WriteData into RAM word DataAdr[log2(DEPTH_WORDS)+1:2] at the clock edge when MemWrite=1 and the address is in RAM range.
REQ-013 SHALL return the addressed RAM word on ReadData with zero latency, so it is valid in the same cycle for capture by the write-back register.
REQ-014 SHALL, on a write to LED, load WriteData[7:0] into led; a read returns {24'b0, led}.
REQ-015 SHALL increment TIMER by 1 every cycle, wrapping from 0xFFFF_FFFF to 0.
REQ-016 SHALL, on a write to TIMER, set it to 0 at that edge; the write takes priority over the increment.
REQ-017 SHALL, on a write to UART_DATA while the UART is idle, latch WriteData[7:0] and start transmission on the next cycle.
REQ-018 SHALL ignore a UART_DATA write while busy, with no change to data or state.
REQ-019 SHALL return {31'b0, busy} on a UART_STAT read, where busy=1 from the accepting edge until the STOP bit completes.
REQ-020 SHALL implement the UART FSM with states IDLE, START, DATA, STOP:
- IDLE: tx=1; goes to START on an accepted write.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: sends bits LSB first, each for CLKS_PER_BIT cycles, tracked by a 3-bit index; goes to STOP after bit 7.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-021 SHALL use a baud counter that counts 0..CLKS_PER_BIT-1, reloads to 0 on each bit boundary, and is held at 0 in IDLE.
REQ-022 SHALL, when busy clears, accept a UART_DATA write in the same cycle that the FSM is in IDLE.
REQ-023 SHALL return 0 on ReadData for unmapped addresses and shall ignore writes to them.
REQ-024 SHALL treat UART_STAT as read-only; writes have no effect.
REQ-025 SHALL produce reads with no side effects.

Reset
REQ-026 SHALL, on asynchronous reset assertion, immediately force:
- led=0
- TIMER=0
- UART state=IDLE
- baud counter=0
- bit index=0
- uart_tx=1
- busy=0
REQ-027 SHALL abort any in-flight transmission on reset and hold uart_tx=1.
REQ-028 SHALL NOT reset RAM contents.
REQ-029 SHALL ignore MemWrite while reset is asserted.

Structure
REQ-030 SHALL place the address-map constants and the UART state encoding in a shared package dmem_pkg.
REQ-031 SHALL implement the UART transmitter as sub-module uart_tx_fsm with ports:
- clk, reset
- start (input), data[7:0] (input)
- busy (output), tx (output)
REQ-032 SHALL keep the address decode, RAM, LED and TIMER in dmem_mmio itself.

Verification
REQ-033 SHALL cover RAM store then load: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> ReadData=0xDEADBEEF in the same cycle as the address is applied; read 0x0000_0013 -> 0xDEADBEEF.
REQ-034 SHALL cover LED: write 0x1234_56A5 to 0x0000_1000 -> led=0xA5; read -> 0x0000_00A5.
REQ-035 SHALL cover TIMER: after 10 cycles out of reset, read -> 10; a write at cycle N returns 0 at N+1 and 1 at N+2; preload 0xFFFF_FFFF via force -> next value 0.
REQ-036 SHALL cover a UART frame with CLKS_PER_BIT=4: write 0x55 -> busy=1 the next cycle; uart_tx shows 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; busy=0 after 40 cycles; a second write 0xFF mid-frame is ignored.
REQ-037 SHALL cover reset during DATA: reset asserted mid-frame -> uart_tx=1, busy=0 immediately; led and TIMER are 0; a RAM word written before reset still reads back unchanged.
REQ-038 SHALL cover unmapped access: write to 0x0000_2000, then read -> 0; no RAM, LED, TIMER or UART state change.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Address map of the data-memory / MMIO block and the UART
//               transmitter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [31:0] c_ADDR_LED       = 32'h0000_1000;
    localparam logic [31:0] c_ADDR_TIMER     = 32'h0000_1004;
    localparam logic [31:0] c_ADDR_UART_DATA = 32'h0000_1008;
    localparam logic [31:0] c_ADDR_UART_STAT = 32'h0000_100C;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uartState_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fsm
// Description : 8N1 serial transmitter; accepts a byte only while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fsm
    import dmem_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);

    uartState_t          r_state;
    uartState_t          w_stateNext;
    logic [c_BAUD_W-1:0] r_baud;
    logic [c_BAUD_W-1:0] w_baudNext;
    logic [2:0]          r_bitIdx;
    logic [2:0]          w_bitIdxNext;
    logic [7:0]          r_data;
    logic [7:0]          w_dataNext;
    logic                w_bitDone;

    assign w_bitDone = (r_baud == c_BAUD_LAST);
    assign busy      = (r_state != UART_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= UART_IDLE;
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_data   <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_baud   <= w_baudNext;
            r_bitIdx <= w_bitIdxNext;
            r_data   <= w_dataNext;
        end
    end

    // Baud counter defaults to 0, so it reloads on every bit boundary and rests in IDLE.
    always_comb begin
        w_stateNext  = r_state;
        w_baudNext   = '0;
        w_bitIdxNext = r_bitIdx;
        w_dataNext   = r_data;
        tx           = 1'b1;
        case (r_state)
            UART_IDLE: begin
                if (start) begin
                    w_stateNext  = UART_START;
                    w_dataNext   = data;
                    w_bitIdxNext = '0;
                end
            end
            UART_START: begin
                tx = 1'b0;
                if (w_bitDone) begin
                    w_stateNext = UART_DATA;
                end else begin
                    w_baudNext = r_baud + c_BAUD_ONE;
                end
            end
            UART_DATA: begin
                tx = r_data[r_bitIdx];
                if (w_bitDone) begin
                    w_bitIdxNext = r_bitIdx + 3'd1;
                    if (r_bitIdx == 3'd7) begin
                        w_stateNext = UART_STOP;
                    end
                end else begin
                    w_baudNext = r_baud + c_BAUD_ONE;
                end
            end
            UART_STOP: begin
                if (w_bitDone) begin
                    w_stateNext = UART_IDLE;
                end else begin
                    w_baudNext = r_baud + c_BAUD_ONE;
                end
            end
            default: begin
                w_stateNext = UART_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio
// Description : Core data memory with memory-mapped LED, free-running timer
//               and UART transmitter; single-cycle combinational load path.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 64,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  led,
    output logic        uart_tx
);

    localparam int c_ADDR_BITS = $clog2(DEPTH_WORDS);

    logic [31:0]            r_mem [DEPTH_WORDS];
    logic [7:0]             r_led;
    logic [31:0]            r_timer;
    logic [c_ADDR_BITS-1:0] w_ramIdx;
    logic                   w_ramSel;
    logic                   w_ledSel;
    logic                   w_timerSel;
    logic                   w_uartDataSel;
    logic                   w_uartStatSel;
    logic                   w_storeEn;
    logic                   w_uartStart;
    logic                   w_uartBusy;
    logic                   w_unused;

    // Byte offset within a word plays no part in decode.
    assign w_unused      = &{1'b0, DataAdr[1:0]};
    assign w_ramIdx      = DataAdr[c_ADDR_BITS+1:2];
    assign w_ramSel      = (DataAdr[31:c_ADDR_BITS+2] == '0);
    assign w_ledSel      = (DataAdr[31:2] == c_ADDR_LED[31:2]);
    assign w_timerSel    = (DataAdr[31:2] == c_ADDR_TIMER[31:2]);
    assign w_uartDataSel = (DataAdr[31:2] == c_ADDR_UART_DATA[31:2]);
    assign w_uartStatSel = (DataAdr[31:2] == c_ADDR_UART_STAT[31:2]);

    assign w_storeEn   = MemWrite & ~reset & w_ramSel;
    assign w_uartStart = MemWrite & w_uartDataSel;
    assign led         = r_led;

    // RAM contents survive reset; only the store strobe is blocked during it.
    always_ff @(posedge clk) begin
        if (w_storeEn) begin
            r_mem[w_ramIdx] <= WriteData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led   <= '0;
            r_timer <= '0;
        end else begin
            if (MemWrite && w_ledSel) begin
                r_led <= WriteData[7:0];
            end
            if (MemWrite && w_timerSel) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 32'd1;
            end
        end
    end

    always_comb begin
        ReadData = '0;
        if (w_ramSel) begin
            ReadData = r_mem[w_ramIdx];
        end else if (w_ledSel) begin
            ReadData = {24'b0, r_led};
        end else if (w_timerSel) begin
            ReadData = r_timer;
        end else if (w_uartStatSel) begin
            ReadData = {31'b0, w_uartBusy};
        end
    end

    uart_tx_fsm #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uartTx (
        .clk   (clk),
        .reset (reset),
        .start (w_uartStart),
        .data  (WriteData[7:0]),
        .busy  (w_uartBusy),
        .tx    (uart_tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_mmio
// Description : Self-checking bench for dmem_mmio with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio;

    localparam int c_DEPTH = 64;
    localparam int c_CPB   = 4;
    localparam int c_FRAME = 10 * c_CPB;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  led;
    logic        uart_tx;

    int nChecks = 0;
    int nFails  = 0;

    dmem_mmio #(
        .DEPTH_WORDS  (c_DEPTH),
        .CLKS_PER_BIT (c_CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .led       (led),
        .uart_tx   (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: memory array, registers, and a frame described by its start cycle.
    logic [31:0] mMem [c_DEPTH];
    bit          mValid [c_DEPTH];
    logic [7:0]  mLed;
    logic [31:0] mTimer;
    longint      mCyc = 0;
    bit          fValid = 0;
    longint      fStart = 0;
    logic [7:0]  fByte;
    bit          forceTimer = 0;
    bit          cmpEn = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 RAM, 1 LED, 2 TIMER, 3 UART_DATA, 4 UART_STAT, 5 unmapped
    function automatic int addrClass(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w < 32'(4 * c_DEPTH)) return 0;
        if (w == 32'h1000) return 1;
        if (w == 32'h1004) return 2;
        if (w == 32'h1008) return 3;
        if (w == 32'h100C) return 4;
        return 5;
    endfunction

    function automatic bit busyAt(input longint c);
        return fValid && (c - fStart) < c_FRAME;
    endfunction

    function automatic logic txAt(input longint c);
        longint k;
        if (!busyAt(c)) return 1'b1;
        k = (c - fStart) / c_CPB;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return fByte[int'(k) - 1];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mLed   = '0;
            mTimer = '0;
            fValid = 0;
        end else begin
            if (MemWrite) begin
                case (addrClass(DataAdr))
                    0: begin
                        mMem[DataAdr[7:2]]   = WriteData;
                        mValid[DataAdr[7:2]] = 1;
                    end
                    1: mLed = WriteData[7:0];
                    3: if (!busyAt(mCyc)) begin
                        fValid = 1;
                        fStart = mCyc + 1;
                        fByte  = WriteData[7:0];
                    end
                    default: ;
                endcase
            end
            if (forceTimer || (MemWrite && addrClass(DataAdr) == 2)) mTimer = '0;
            else mTimer = mTimer + 32'd1;
            mCyc++;
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            check("led", {24'b0, led}, {24'b0, mLed});
            check("uart_tx", {31'b0, uart_tx}, {31'b0, txAt(mCyc)});
            case (addrClass(DataAdr))
                0: if (mValid[DataAdr[7:2]]) check("ram_read", ReadData, mMem[DataAdr[7:2]]);
                1: check("led_read", ReadData, {24'b0, mLed});
                2: check("timer_read", ReadData, mTimer);
                4: check("stat_read", ReadData, {31'b0, busyAt(mCyc)});
                5: check("unmapped_read", ReadData, 32'h0);
                default: ;
            endcase
        end
    end

    task automatic step(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        @(posedge clk);
        #1;
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = wd;
        #1;
    endtask

    logic [9:0] frame55;

    initial begin
        for (int i = 0; i < c_DEPTH; i++) mValid[i] = 0;
        reset = 1'b1;
        MemWrite = 1'b0; DataAdr = 32'h1004; WriteData = '0;
        cmpEn = 1;
        repeat (3) step(0, 32'h1004, 0);
        check("reset_led", {24'b0, led}, 32'h0);
        check("reset_tx", {31'b0, uart_tx}, 32'h1);
        check("reset_timer", ReadData, 32'h0);

        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) step(0, 32'h1004, 0);
        check("timer_after_10", ReadData, 32'd10);

        step(1, 32'h1004, 32'h1234);
        step(0, 32'h1004, 0);
        check("timer_wr_n1", ReadData, 32'd0);
        step(0, 32'h1004, 0);
        check("timer_wr_n2", ReadData, 32'd1);

        step(0, 32'h1000, 0);
        force dut.r_timer = 32'hFFFF_FFFF;
        forceTimer = 1;
        #1 release dut.r_timer;
        step(0, 32'h1004, 0);
        forceTimer = 0;
        check("timer_wrap", ReadData, 32'd0);

        step(1, 32'h10, 32'hDEAD_BEEF);
        step(0, 32'h10, 0);
        check("ram_10", ReadData, 32'hDEAD_BEEF);
        step(0, 32'h13, 0);
        check("ram_13", ReadData, 32'hDEAD_BEEF);

        step(1, 32'h1000, 32'h1234_56A5);
        step(0, 32'h1000, 0);
        check("led_out", {24'b0, led}, 32'hA5);
        check("led_read_lit", ReadData, 32'h0000_00A5);

        frame55 = 10'b10_1010_1010;
        step(1, 32'h1008, 32'h55);
        step(0, 32'h100C, 0);
        check("uart_busy_next", ReadData, 32'h1);
        for (int i = 0; i < c_FRAME; i++) begin
            check("uart_bit", {31'b0, uart_tx}, {31'b0, frame55[i / c_CPB]});
            if (i == 13) step(1, 32'h1008, 32'hFF);
            else step(0, 32'h100C, 0);
        end
        check("uart_idle_40", ReadData, 32'h0);
        check("uart_idle_tx", {31'b0, uart_tx}, 32'h1);

        step(1, 32'h2000, 32'hCAFE_F00D);
        step(0, 32'h2000, 0);
        check("unmapped_lit", ReadData, 32'h0);
        check("unmapped_led", {24'b0, led}, 32'hA5);
        step(0, 32'h10, 0);
        check("unmapped_ram", ReadData, 32'hDEAD_BEEF);

        for (int n = 0; n < 2000; n++) begin
            int sel;
            logic [31:0] a;
            logic we;
            sel = int'($urandom_range(0, 99));
            we  = 1'($urandom_range(0, 1));
            if (sel < 35) a = 32'($urandom_range(0, c_DEPTH - 1)) << 2;
            else if (sel < 45) a = 32'h1000;
            else if (sel < 55) begin a = 32'h1004; we = ($urandom_range(0, 4) == 0); end
            else if (sel < 75) a = 32'h1008;
            else if (sel < 90) a = 32'h100C;
            else begin
                case ($urandom_range(0, 3))
                    0: a = 32'h100 + (32'($urandom_range(0, 63)) << 2);
                    1: a = 32'h1010;
                    2: a = 32'h0FFC;
                    default: a = 32'h8000_1000;
                endcase
            end
            a = a | 32'($urandom_range(0, 3));
            step(we, a, $urandom);
        end

        for (int i = 0; i < c_FRAME + 2; i++) step(0, 32'h100C, 0);
        step(1, 32'h20, 32'h600D_F00D);
        step(1, 32'h24, 32'hAAAA_5555);
        step(1, 32'h1000, 32'h3C);
        step(1, 32'h1008, 32'hA3);
        for (int i = 0; i < 12; i++) step(0, 32'h100C, 0);
        check("busy_before_rst", ReadData, 32'h1);
        #1 reset = 1'b1;
        #1;
        check("rst_tx", {31'b0, uart_tx}, 32'h1);
        check("rst_busy", ReadData, 32'h0);
        check("rst_led", {24'b0, led}, 32'h0);
        DataAdr = 32'h1004; #1;
        check("rst_timer", ReadData, 32'h0);
        DataAdr = 32'h20; #1;
        check("rst_ram", ReadData, 32'h600D_F00D);
        step(1, 32'h24, 32'h1111_1111);
        step(1, 32'h1000, 32'hFF);
        step(0, 32'h1004, 0);
        check("rst_timer_held", ReadData, 32'h0);
        reset = 1'b0;
        step(0, 32'h24, 0);
        check("rst_ram_nowrite", ReadData, 32'hAAAA_5555);
        check("rst_led_nowrite", {24'b0, led}, 32'h0);
        step(0, 32'h100C, 0);

        cmpEn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
